// File: rtl/branch_target_predictor.sv
// Fully-associative branch target buffer with per-entry saturating direction counters,
// EX-stage mispredict detection and saturating hit/branch/mispredict statistics.
module branch_target_predictor #(
    parameter int ENTRIES   = 8,
    parameter int PC_BITS   = 32,
    parameter int CNT_BITS  = 2,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 lk_valid,
    input  logic [PC_BITS-1:0]   lk_pc,
    output logic                 lk_hit,
    output logic                 lk_pred_taken,
    output logic [PC_BITS-1:0]   lk_pred_pc,
    input  logic                 upd_valid,
    input  logic [PC_BITS-1:0]   upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_BITS-1:0]   upd_target,
    input  logic                 upd_pred_taken,
    input  logic [PC_BITS-1:0]   upd_pred_pc,
    output logic                 mispredict,
    output logic [PC_BITS-1:0]   redirect_pc,
    output logic [STAT_BITS-1:0] hit_cnt,
    output logic [STAT_BITS-1:0] branch_cnt,
    output logic [STAT_BITS-1:0] mispredict_cnt
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = PC_BITS - 2;
    localparam logic [CNT_BITS-1:0]  CNT_RESET = CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);
    localparam logic [CNT_BITS-1:0]  CNT_ALLOC = CNT_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0]  CNT_MIN   = {CNT_BITS{1'b0}};
    localparam logic [STAT_BITS-1:0] STAT_MAX  = {STAT_BITS{1'b1}};
    localparam logic [PC_BITS-1:0]   PC_STEP   = PC_BITS'(4);

    logic [ENTRIES-1:0]  valid_r;
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [PC_BITS-1:0]  target_r [ENTRIES];
    logic [CNT_BITS-1:0] cnt_r    [ENTRIES];
    logic [IDX_BITS-1:0] ptr_r;

    logic                lk_match_s;
    logic [IDX_BITS-1:0] lk_idx_s;
    logic                upd_match_s;
    logic [IDX_BITS-1:0] upd_idx_s;
    logic                free_found_s;
    logic [IDX_BITS-1:0] free_idx_s;
    logic [IDX_BITS-1:0] alloc_idx_s;
    logic [PC_BITS-1:0]  correct_pc_s;
    logic                unused_s;

    function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] cnt,
                                                     input logic taken);
        if (taken && (cnt != CNT_MAX)) begin
            cnt_next = cnt + CNT_BITS'(1);
        end else if (!taken && (cnt != CNT_MIN)) begin
            cnt_next = cnt - CNT_BITS'(1);
        end else begin
            cnt_next = cnt;
        end
    endfunction

    function automatic logic [STAT_BITS-1:0] stat_inc(input logic [STAT_BITS-1:0] val,
                                                      input logic inc);
        if (inc && (val != STAT_MAX)) begin
            stat_inc = val + STAT_BITS'(1);
        end else begin
            stat_inc = val;
        end
    endfunction

    // Byte offsets and the carried prediction bit do not influence the table.
    assign unused_s = ^{lk_pc[1:0], upd_pc[1:0], upd_pred_taken};

    // Associative search for the lookup and update ports plus free-slot selection.
    always_comb begin
        lk_match_s   = 1'b0;
        lk_idx_s     = '0;
        upd_match_s  = 1'b0;
        upd_idx_s    = '0;
        free_found_s = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_r[i] && (tag_r[i] == lk_pc[PC_BITS-1:2])) begin
                lk_match_s = 1'b1;
                lk_idx_s   = IDX_BITS'(i);
            end else begin
                lk_match_s = lk_match_s;
            end
            if (valid_r[i] && (tag_r[i] == upd_pc[PC_BITS-1:2])) begin
                upd_match_s = 1'b1;
                upd_idx_s   = IDX_BITS'(i);
            end else begin
                upd_match_s = upd_match_s;
            end
        end
        // Walk downward so the lowest-index invalid entry is the one kept.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_BITS'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
        alloc_idx_s = free_found_s ? free_idx_s : ptr_r;
    end

    // Zero-latency prediction and EX-stage mispredict resolution.
    always_comb begin
        lk_hit        = lk_valid & lk_match_s;
        lk_pred_taken = lk_hit & cnt_r[lk_idx_s][CNT_BITS-1];
        lk_pred_pc    = lk_pred_taken ? target_r[lk_idx_s] : (lk_pc + PC_STEP);
        correct_pc_s  = upd_taken ? upd_target : (upd_pc + PC_STEP);
        mispredict    = upd_valid & (correct_pc_s != upd_pred_pc);
        redirect_pc   = correct_pc_s;
    end

    // Table state: training on match, allocation on taken miss, bulk invalidation on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            ptr_r   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                cnt_r[i]    <= CNT_RESET;
            end
        end else if (en) begin
            if (flush) begin
                valid_r <= '0;
            end else if (upd_valid) begin
                if (upd_match_s) begin
                    cnt_r[upd_idx_s] <= cnt_next(cnt_r[upd_idx_s], upd_taken);
                    if (upd_taken) begin
                        target_r[upd_idx_s] <= upd_target;
                    end
                end else if (upd_taken) begin
                    valid_r[alloc_idx_s]  <= 1'b1;
                    tag_r[alloc_idx_s]    <= upd_pc[PC_BITS-1:2];
                    target_r[alloc_idx_s] <= upd_target;
                    cnt_r[alloc_idx_s]    <= CNT_ALLOC;
                    if (!free_found_s) begin
                        ptr_r <= ptr_r + IDX_BITS'(1);
                    end
                end
            end
        end
    end

    // Saturating statistics; a flushed update still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt        <= '0;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (en) begin
            hit_cnt        <= stat_inc(hit_cnt, lk_hit);
            branch_cnt     <= stat_inc(branch_cnt, upd_valid);
            mispredict_cnt <= stat_inc(mispredict_cnt, mispredict);
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table for prediction/training,
// hand sequences for stall, flush, replacement wrap, reset and statistic saturation.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst, en, flush, lk_valid, upd_valid, upd_taken, upd_pred_taken;
    logic [31:0] lk_pc, upd_pc, upd_target, upd_pred_pc;
    logic        lk_hit, lk_pred_taken, mispredict;
    logic [31:0] lk_pred_pc, redirect_pc, hit_cnt, branch_cnt, mispredict_cnt;
    logic        s_hit, s_pt, s_mis;
    logic [31:0] s_ppc, s_redir;
    logic [3:0]  s_hit_cnt, s_branch_cnt, s_mis_cnt;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    branch_target_predictor dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_hit(lk_hit),
        .lk_pred_taken(lk_pred_taken), .lk_pred_pc(lk_pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .hit_cnt(hit_cnt), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    branch_target_predictor #(.STAT_BITS(4)) u_small (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_hit(s_hit),
        .lk_pred_taken(s_pt), .lk_pred_pc(s_ppc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc),
        .mispredict(s_mis), .redirect_pc(s_redir),
        .hit_cnt(s_hit_cnt), .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mis_cnt)
    );

    typedef struct {
        logic        en, flush, lkv;
        logic [31:0] lkpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uppc;
        logic        e_hit, e_pt;
        logic [31:0] e_ppc;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(logic lkv, logic [31:0] lkpc, logic uv, logic [31:0] upc,
                                logic ut, logic [31:0] utgt, logic upt, logic [31:0] uppc,
                                logic eh, logic ept, logic [31:0] eppc, logic emis,
                                logic [31:0] eredir);
        vec_t v;
        v.en = 1'b1; v.flush = 1'b0; v.lkv = lkv; v.lkpc = lkpc;
        v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uppc = uppc;
        v.e_hit = eh; v.e_pt = ept; v.e_ppc = eppc; v.e_mis = emis; v.e_redir = eredir;
        return v;
    endfunction

    function automatic logic [31:0] sat4(input logic [31:0] x);
        return (x > 32'd15) ? 32'd15 : x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic idle();
        rst = 1'b0; en = 1'b1; flush = 1'b0; lk_valid = 1'b0; lk_pc = 32'h0;
        upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
        upd_pred_taken = 1'b0; upd_pred_pc = 32'h0;
    endtask

    task automatic check_stats(input logic [31:0] h, input logic [31:0] b,
                               input logic [31:0] m, input string name);
        @(negedge clk); idle(); en = 1'b0; #1;
        check({name, "_hit_cnt"}, hit_cnt, h);
        check({name, "_branch_cnt"}, branch_cnt, b);
        check({name, "_mis_cnt"}, mispredict_cnt, m);
        check({name, "_small_hit_cnt"}, s_hit_cnt, sat4(h));
        check({name, "_small_branch_cnt"}, s_branch_cnt, sat4(b));
        check({name, "_small_mis_cnt"}, s_mis_cnt, sat4(m));
    endtask

    // Taken update of pc with target pc+0x1000; IF predicted fall-through.
    task automatic upd(input logic [31:0] pc);
        @(negedge clk); idle();
        upd_valid = 1'b1; upd_pc = pc; upd_taken = 1'b1;
        upd_target = pc + 32'h1000; upd_pred_pc = pc + 32'd4;
    endtask

    // Stalled lookup (no side effects); a hit predicts that allocation's target.
    task automatic look(input logic [31:0] pc, input logic exp_hit, input string name);
        @(negedge clk); idle(); en = 1'b0; lk_valid = 1'b1; lk_pc = pc; #1;
        check({name, "_hit"}, lk_hit, exp_hit);
        check({name, "_ppc"}, lk_pred_pc, exp_hit ? pc + 32'h1000 : pc + 32'd4);
    endtask

    initial begin
        //             lkv  lkpc      uv  upc       ut  utgt      upt uppc      hit pt  ppc       mis redir
        tbl[0]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b1, 32'h123, 1'b0, 32'h0,   1'b0, 1'b0, 32'h44,  1'b0, 32'h123);
        tbl[1]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b0, 1'b0, 32'h44,  1'b1, 32'h100);
        tbl[2]  = mk(1'b1, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
        tbl[3]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h44);
        tbl[4]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 32'h44);
        tbl[5]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 32'h44);
        tbl[6]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b0, 32'h44);
        tbl[7]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b1, 32'h100);
        tbl[8]  = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b1, 1'b0, 32'h44,  1'b1, 32'h100);
        tbl[9]  = mk(1'b1, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
        tbl[10] = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100);
        tbl[11] = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100);
        tbl[12] = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h100);
        tbl[13] = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h44);
        tbl[14] = mk(1'b1, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h44);
        tbl[15] = mk(1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0,   1'b0, 32'h84,  1'b0, 1'b0, 32'h84,  1'b0, 32'h84);
        tbl[16] = mk(1'b1, 32'h80, 1'b0, 32'h80, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b0, 32'h84);
        tbl[17] = mk(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200);
        tbl[18] = mk(1'b1, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h44);
        tbl[19] = mk(1'b0, 32'h40, 1'b0, 32'h40, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h44,  1'b0, 32'h44);

        idle(); rst = 1'b1;
        repeat (2) @(posedge clk);
        check_stats(32'd0, 32'd0, 32'd0, "reset");

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst = 1'b0; en = tbl[i].en; flush = tbl[i].flush;
            lk_valid = tbl[i].lkv; lk_pc = tbl[i].lkpc;
            upd_valid = tbl[i].uv; upd_pc = tbl[i].upc; upd_taken = tbl[i].ut;
            upd_target = tbl[i].utgt; upd_pred_taken = tbl[i].upt; upd_pred_pc = tbl[i].uppc;
            #1;
            check($sformatf("v%0d_hit", i), lk_hit, tbl[i].e_hit);
            check($sformatf("v%0d_pred_taken", i), lk_pred_taken, tbl[i].e_pt);
            check($sformatf("v%0d_pred_pc", i), lk_pred_pc, tbl[i].e_ppc);
            check($sformatf("v%0d_mispredict", i), mispredict, tbl[i].e_mis);
            check($sformatf("v%0d_redirect", i), redirect_pc, tbl[i].e_redir);
        end
        check_stats(32'd15, 32'd13, 32'd6, "table");

        // Stall: everything requested, nothing may change.
        @(negedge clk); idle();
        en = 1'b0; flush = 1'b1; lk_valid = 1'b1; lk_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h300; upd_pred_pc = 32'h44;
        #1;
        check("stall_hit", lk_hit, 1'b1);
        check("stall_pred_pc", lk_pred_pc, 32'h200);
        check("stall_mispredict", mispredict, 1'b1);
        check("stall_redirect", redirect_pc, 32'h300);
        check_stats(32'd15, 32'd13, 32'd6, "stall");
        @(negedge clk); idle(); en = 1'b0; lk_valid = 1'b1; lk_pc = 32'h40; #1;
        check("stall_kept_hit", lk_hit, 1'b1);
        check("stall_kept_ppc", lk_pred_pc, 32'h200);

        // Flush with concurrent (dropped but counted) update.
        @(negedge clk); idle(); flush = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100; upd_pred_pc = 32'h200;
        check_stats(32'd15, 32'd14, 32'd7, "flush");
        look(32'h40, 1'b0, "flush_40");
        look(32'h80, 1'b0, "flush_80");

        // Capacity and round-robin replacement.
        for (int k = 0; k < 8; k++) upd(32'(k * 4));
        look(32'h00, 1'b1, "fill_00");
        look(32'h1C, 1'b1, "fill_1c");
        upd(32'h20);
        look(32'h00, 1'b0, "repl0_00");
        look(32'h04, 1'b1, "repl0_04");
        look(32'h20, 1'b1, "repl0_20");
        upd(32'h24);
        look(32'h04, 1'b0, "repl1_04");
        look(32'h08, 1'b1, "repl1_08");
        for (int k = 10; k < 16; k++) upd(32'(k * 4));
        upd(32'h40);
        look(32'h20, 1'b0, "wrap_20");
        look(32'h24, 1'b1, "wrap_24");
        look(32'h40, 1'b1, "wrap_40");

        // Reset mid-sequence beats a concurrent update and lookup.
        @(negedge clk); idle(); rst = 1'b1; lk_valid = 1'b1; lk_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1; upd_target = 32'h900;
        check_stats(32'd0, 32'd0, 32'd0, "rst");
        look(32'h40, 1'b0, "rst_40");
        look(32'h3C, 1'b0, "rst_3c");
        look(32'h44, 1'b0, "rst_44");

        // Pointer restarts at 0 after reset; then saturate the 4-bit hit counter.
        for (int k = 0; k < 8; k++) upd(32'(k * 4));
        upd(32'h20);
        look(32'h00, 1'b0, "ptr_rst_00");
        look(32'h04, 1'b1, "ptr_rst_04");
        @(negedge clk); idle(); lk_valid = 1'b1; lk_pc = 32'h20;
        repeat (19) @(negedge clk);
        check_stats(32'd20, 32'd9, 32'd9, "sat");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
